// File: rtl/buff_reader.sv
// Drains an upstream circular buffer into a 2-entry skid store feeding a valid/ready stream.
// Tracks buffer occupancy locally and flags any push issued while the buffer is full.
module buff_reader #(
  parameter int NUMELEM = 4,
  parameter int BITDATA = 4,
  localparam int BITELEM = $clog2(NUMELEM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_in,
  output logic               pop,
  input  logic [BITDATA-1:0] po_dout,
  output logic               m_valid,
  output logic [BITDATA-1:0] m_data,
  input  logic               m_ready,
  output logic [BITELEM:0]   occ,
  output logic               empty,
  output logic               full,
  output logic               ovf
);

  localparam logic [BITELEM:0] OCC_MAX = (BITELEM+1)'(NUMELEM);

  logic [BITELEM:0]   r_occ;
  logic [1:0]         r_sk;
  logic [BITDATA-1:0] r_slot0;
  logic [BITDATA-1:0] r_slot1;
  logic               r_valid;
  logic               r_ovf;

  logic               w_pop;
  logic               w_xfer;
  logic               w_illegal;
  logic [1:0]         w_skShift;
  logic [1:0]         w_skNext;

  // pop depends only on registered state so the upstream buffer sees no path from m_ready/push_in
  assign w_pop     = (r_occ != '0) && (r_sk != 2'd2) && !rst;
  assign w_xfer    = r_valid && m_ready;
  assign w_illegal = push_in && (r_occ == OCC_MAX);
  assign w_skShift = r_sk - 2'(w_xfer);
  assign w_skNext  = w_skShift + 2'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
      r_ovf <= 1'b0;
    end else if (w_illegal) begin
      r_occ <= OCC_MAX;
      r_ovf <= 1'b1;
    end else begin
      r_occ <= r_occ + (BITELEM+1)'(push_in) - (BITELEM+1)'(w_pop);
    end
  end

  // Capture lands in the first slot left free once any same-cycle transfer has shifted slot1 down
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sk    <= 2'd0;
      r_valid <= 1'b0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      if (w_xfer) begin
        r_slot0 <= r_slot1;
      end
      if (w_pop) begin
        if (w_skShift == 2'd0) begin
          r_slot0 <= po_dout;
        end else begin
          r_slot1 <= po_dout;
        end
      end
      r_sk    <= w_skNext;
      r_valid <= (w_skNext != 2'd0);
    end
  end

  assign pop     = w_pop;
  assign m_valid = r_valid;
  assign m_data  = r_slot0;
  assign occ     = r_occ;
  assign empty   = (r_occ == '0);
  assign full    = (r_occ == OCC_MAX);
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_buff_reader.sv
// Self-checking bench for buff_reader: a circular-buffer environment plus a queue-based
// reference model of the whole buffer+skid system, driven by directed and random stimulus.
module tb_buff_reader;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       push_in;
  logic       pop;
  logic [3:0] po_dout;
  logic       m_valid;
  logic [3:0] m_data;
  logic       m_ready;
  logic [2:0] occ;
  logic       empty;
  logic       full;
  logic       ovf;

  logic [3:0] pushData;
  logic [3:0] mem [N];
  int         head;
  int         tail;
  int         bcnt;

  int         assertCount = 0;
  int         failCount   = 0;

  int         occM = 0;
  int         skM  = 0;
  logic       ovfM = 1'b0;
  logic [3:0] q[$];

  buff_reader #(.NUMELEM(N), .BITDATA(4)) dut (
    .clk(clk), .rst(rst), .push_in(push_in), .pop(pop), .po_dout(po_dout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .occ(occ),
    .empty(empty), .full(full), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream circular buffer: head data is always presented, push ignored when full
  assign po_dout = mem[head];
  always @(posedge clk) begin
    if (rst) begin
      head <= 0;
      tail <= 0;
      bcnt <= 0;
    end else begin
      if (push_in && bcnt < N) begin
        mem[tail] <= pushData;
        tail      <= (tail + 1) % N;
      end
      if (pop) head <= (head + 1) % N;
      bcnt <= bcnt + ((push_in && bcnt < N) ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive, check at negedge against the model, then advance the model at posedge
  task automatic applyStimulus(input logic p, input logic [3:0] d, input logic r, input logic rs);
    logic popM;
    logic xferM;
    rst      = rs;
    push_in  = p;
    pushData = d;
    m_ready  = r;
    popM  = !rs && occM != 0 && skM < 2;
    xferM = skM != 0 && r;
    @(negedge clk);
    checkOutput("pop", pop, popM);
    checkOutput("occ", occ, occM);
    checkOutput("empty", empty, occM == 0);
    checkOutput("full", full, occM == N);
    checkOutput("m_valid", m_valid, skM != 0);
    checkOutput("ovf", ovf, ovfM);
    if (skM != 0) checkOutput("m_data", m_data, q[0]);
    @(posedge clk);
    if (rs) begin
      occM = 0;
      skM  = 0;
      ovfM = 1'b0;
      q.delete();
    end else begin
      if (p && occM == N) ovfM = 1'b1;
      else if (p) q.push_back(d);
      occM = occM + (p ? 1 : 0) - (popM ? 1 : 0);
      if (occM > N) occM = N;
      skM = skM + (popM ? 1 : 0) - (xferM ? 1 : 0);
      if (xferM) void'(q.pop_front());
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; push_in = 1'b0; pushData = '0; m_ready = 1'b0;
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("resetMdata", m_data, 4'h0);

    // Single element through an always-ready sink
    applyStimulus(1, 4'hA, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);

    // Backpressure: two pops fill the skid store, then drain in order
    for (int i = 1; i <= 4; i++) applyStimulus(1, 4'(i), 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("bpOcc2", occ, 3'd2);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0);

    // Fill to NUMELEM+2, then an illegal push sets sticky ovf
    for (int i = 0; i < 6; i++) applyStimulus(1, 4'(i + 6), 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fillFull", full, 1'b1);
    applyStimulus(1, 4'hF, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("ovfSticky", ovf, 1'b1);
    applyStimulus(0, 0, 0, 1);

    // Streaming at one element per cycle keeps occ at most 1
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 4'(i), 1, 0);
      checkOutput("occLe1", occ <= 3'd1, 1'b1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

    // Mid-operation reset with occ=3, sk=2
    for (int i = 1; i <= 5; i++) applyStimulus(1, 4'(i), 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("midOcc3", occ, 3'd3);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 4'h5, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

    // Random traffic; upstream never pushes while the buffer is full
    for (int i = 0; i < 500; i++) begin
      logic rs;
      logic p;
      rs = ($urandom_range(0, 99) == 0);
      p  = (occM < N) && ($urandom_range(0, 2) != 0);
      applyStimulus(p, 4'($urandom), 1'($urandom), rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
